// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator call scheduler slice.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 10;
  localparam int DEF_FLOOR_W    = 4;

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_UP,
    SERVE_DOWN,
    DWELL
  } state_t;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between the call scheduler and the elevator state machine.
// door_hold exists only when DOOR_HOLD_EN is defined.
interface elevator_call_scheduler_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic [FLOOR_W-1:0]    requested_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  door_open;
  logic                  dir_up;
`ifdef DOOR_HOLD_EN
  logic                  door_hold;

  modport master (
    output call_req, current_floor, door_hold,
    input  requested_floor, pending, door_open, dir_up
  );
  modport slave (
    input  call_req, current_floor, door_hold,
    output requested_floor, pending, door_open, dir_up
  );
`else
  modport master (
    output call_req, current_floor,
    input  requested_floor, pending, door_open, dir_up
  );
  modport slave (
    input  call_req, current_floor,
    output requested_floor, pending, door_open, dir_up
  );
`endif
endinterface

// File: rtl/elevator_call_picker.sv
// Finds the nearest latched call above and below the current floor, and a call here.
// An out-of-range current floor reports nothing.
module elevator_call_picker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    above,
  output logic                  above_valid,
  output logic [FLOOR_W-1:0]    below,
  output logic                  below_valid,
  output logic                  here
);
  logic [31:0] cf;

  always_comb begin
    cf          = 32'(current_floor);
    above       = '0;
    above_valid = 1'b0;
    below       = '0;
    below_valid = 1'b0;
    here        = 1'b0;
    if (cf < 32'(NUM_FLOORS)) begin
      // ascending scan: first hit above is nearest, last hit below is nearest
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i]) begin
          if (i < cf) begin
            below       = FLOOR_W'(i);
            below_valid = 1'b1;
          end else if (i == cf) begin
            here = 1'b1;
          end else if (!above_valid) begin
            above       = FLOOR_W'(i);
            above_valid = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches call buttons, picks the next target, dwells at each stop.
// Optional DOOR_HOLD_EN adds door_hold, which freezes the dwell countdown.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int FLOOR_W      = DEF_FLOOR_W,
  parameter int DWELL_CYCLES = 16
) (
  input logic                      clk,
  input logic                      reset,
  elevator_call_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t                state, state_next;
  logic [NUM_FLOORS-1:0] pending_q, pending_next, cur_onehot;
  logic [FLOOR_W-1:0]    req_q, req_next, above, below, up_dist, down_dist;
  logic                  above_valid, below_valid, here, cur_valid;
  logic                  door_q, door_next, dir_q, dir_next;
  logic                  reload, hold, dwell_done, dwell_entry;
  logic [CNT_W-1:0]      cnt_q, cnt_next;

  elevator_call_picker #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_picker (
    .pending      (pending_q),
    .current_floor(bus.current_floor),
    .above        (above),
    .above_valid  (above_valid),
    .below        (below),
    .below_valid  (below_valid),
    .here         (here)
  );

  always_comb begin
    cur_valid = 32'(bus.current_floor) < 32'(NUM_FLOORS);
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      cur_onehot[i] = (32'(bus.current_floor) == i);
    end
  end

`ifdef DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  assign up_dist     = above - bus.current_floor;
  assign down_dist   = bus.current_floor - below;
  assign reload      = (state == DWELL) && |(bus.call_req & cur_onehot);
  assign dwell_done  = !reload && !hold && (cnt_q == '0);
  assign dwell_entry = (state != DWELL) && (state_next == DWELL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending_q <= '0;
      req_q     <= '0;
      door_q    <= 1'b0;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state     <= state_next;
      pending_q <= pending_next;
      req_q     <= req_next;
      door_q    <= door_next;
      dir_q     <= dir_next;
      cnt_q     <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == DWELL) begin
      if (dwell_done) begin
        if (dir_q && above_valid)  state_next = SERVE_UP;
        else if (below_valid)      state_next = SERVE_DOWN;
        else if (above_valid)      state_next = SERVE_UP;
        else                       state_next = IDLE;
      end
    end else if (cur_valid) begin
      if (here) begin
        state_next = DWELL;
      end else begin
        case (state)
          IDLE: begin
            if (above_valid && below_valid)
              state_next = (up_dist <= down_dist) ? SERVE_UP : SERVE_DOWN;
            else if (above_valid) state_next = SERVE_UP;
            else if (below_valid) state_next = SERVE_DOWN;
          end
          SERVE_UP:   if (!above_valid) state_next = below_valid ? SERVE_DOWN : IDLE;
          SERVE_DOWN: if (!below_valid) state_next = above_valid ? SERVE_UP : IDLE;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // a press at the floor being served only reloads the dwell; it is never latched
    pending_next = pending_q | (bus.call_req & ~({NUM_FLOORS{state == DWELL}} & cur_onehot));
    if (dwell_entry) pending_next = pending_next & ~cur_onehot;

    cnt_next = '0;
    if (dwell_entry) begin
      cnt_next = CNT_LOAD;
    end else if (state == DWELL) begin
      if (reload)             cnt_next = CNT_LOAD;
      else if (hold)          cnt_next = cnt_q;
      else if (cnt_q != '0)   cnt_next = cnt_q - CNT_W'(1);
    end

    door_next = (state_next == DWELL);

    req_next = req_q;
    if (cur_valid) begin
      case (state_next)
        SERVE_UP:   req_next = above;
        SERVE_DOWN: req_next = below;
        default:    req_next = bus.current_floor;
      endcase
    end

    dir_next = dir_q;
    if (state_next == SERVE_UP)   dir_next = 1'b1;
    if (state_next == SERVE_DOWN) dir_next = 1'b0;
  end

  assign bus.pending         = pending_q;
  assign bus.requested_floor = req_q;
  assign bus.door_open       = door_q;
  assign bus.dir_up          = dir_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus a randomized run against a reference model.
module tb_elevator_call_scheduler;
  import elevator_pkg::*;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int DW = 16;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passes = 0;

  elevator_call_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_call_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .DWELL_CYCLES(DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model: latched calls, mode (idle / moving / door open), heading, open cycles left
  logic [NF-1:0] m_calls;
  int            m_req;
  int            m_mode;
  bit            m_dir;
  int            m_left;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_calls = '0;
    m_req   = 0;
    m_mode  = M_IDLE;
    m_dir   = 1'b1;
    m_left  = 0;
  endfunction

  function automatic void head(input bit up, input int f);
    m_mode = M_MOVE;
    m_dir  = up;
    m_req  = f;
  endfunction

  function automatic void model_step();
    int cf, ab, bl;
    bit valid, hr, hold;
    logic [NF-1:0] req, nxt;
    cf   = int'(bus.current_floor);
    req  = bus.call_req;
    hold = 1'b0;
`ifdef DOOR_HOLD_EN
    hold = bus.door_hold;
`endif
    valid = cf < NF;
    ab = -1;
    bl = -1;
    hr = 1'b0;
    if (valid) begin
      hr = m_calls[cf];
      for (int f = cf + 1; f < NF; f++) if (m_calls[f]) begin ab = f; break; end
      for (int f = cf - 1; f >= 0; f--) if (m_calls[f]) begin bl = f; break; end
    end
    nxt = m_calls | req;
    if (m_mode == M_DOOR) begin
      if (valid) m_req = cf;
      if (valid && req[cf]) begin
        nxt[cf] = m_calls[cf];
        m_left  = DW;
      end else if (!hold) begin
        if (m_left > 1)            m_left--;
        else if (m_dir && ab >= 0) head(1'b1, ab);
        else if (bl >= 0)          head(1'b0, bl);
        else if (ab >= 0)          head(1'b1, ab);
        else                       m_mode = M_IDLE;
      end
    end else if (valid) begin
      if (hr) begin
        m_mode  = M_DOOR;
        m_left  = DW;
        nxt[cf] = 1'b0;
        m_req   = cf;
      end else if (m_mode == M_IDLE && ab >= 0 && bl >= 0) begin
        if (ab - cf <= cf - bl) head(1'b1, ab);
        else                    head(1'b0, bl);
      end else if (m_mode == M_MOVE && m_dir && ab >= 0) head(1'b1, ab);
      else if (m_mode == M_MOVE && !m_dir && bl >= 0)    head(1'b0, bl);
      else if (ab >= 0)                                  head(1'b1, ab);
      else if (bl >= 0)                                  head(1'b0, bl);
      else begin
        m_mode = M_IDLE;
        m_req  = cf;
      end
    end
    m_calls = nxt;
  endfunction

  task automatic compare();
    check("pending", 32'(bus.pending), 32'(m_calls));
    check("requested_floor", 32'(bus.requested_floor), 32'(m_req));
    check("door_open", 32'(bus.door_open), 32'(m_mode == M_DOOR));
    check("dir_up", 32'(bus.dir_up), 32'(m_dir));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic press(input int f);
    bus.call_req    = '0;
    bus.call_req[f] = 1'b1;
  endtask

  int     n;
  floor_t real_cf;

  initial begin
    bus.call_req      = '0;
    bus.current_floor = '0;
`ifdef DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    model_reset();
    #2;
    do_reset();

    // call ahead of an idle car
    bus.current_floor = 4'd0;
    press(5);
    cycle();
    check("t1_pending", 32'(bus.pending), 32'h020);
    bus.call_req = '0;
    cycle();
    check("t1_req", 32'(bus.requested_floor), 32'd5);
    check("t1_dir", 32'(bus.dir_up), 32'd1);

    // retarget to a nearer call on the way, then dwell and resume
    do_reset();
    bus.current_floor = 4'd3;
    press(7);
    cycle();
    bus.call_req = '0;
    cycle();
    check("t2_req7", 32'(bus.requested_floor), 32'd7);
    press(4);
    cycle();
    bus.call_req = '0;
    cycle();
    check("t2_retarget", 32'(bus.requested_floor), 32'd4);
    bus.current_floor = 4'd4;
    cycle();
    check("t2_door", 32'(bus.door_open), 32'd1);
    check("t2_clear4", 32'(bus.pending[4]), 32'd0);
    for (int i = 0; i < DW - 1; i++) begin
      cycle();
      check("t2_door_held", 32'(bus.door_open), 32'd1);
    end
    cycle();
    check("t2_door_closed", 32'(bus.door_open), 32'd0);
    check("t2_resume", 32'(bus.requested_floor), 32'd7);

    // equidistant tie goes up, then sweep reverses
    do_reset();
    bus.current_floor = 4'd5;
    bus.call_req      = '0;
    bus.call_req[3]   = 1'b1;
    bus.call_req[7]   = 1'b1;
    cycle();
    bus.call_req = '0;
    cycle();
    check("t3_tie_req", 32'(bus.requested_floor), 32'd7);
    check("t3_tie_dir", 32'(bus.dir_up), 32'd1);
    bus.current_floor = 4'd7;
    cycle();
    repeat (DW) cycle();
    check("t3_rev_dir", 32'(bus.dir_up), 32'd0);
    check("t3_rev_req", 32'(bus.requested_floor), 32'd3);

    // press at the served floor during dwell restarts the countdown
    do_reset();
    bus.current_floor = 4'd2;
    press(2);
    cycle();
    bus.call_req = '0;
    cycle();
    check("t4_door", 32'(bus.door_open), 32'd1);
    repeat (12) cycle();
    press(2);
    cycle();
    bus.call_req = '0;
    check("t4_not_latched", 32'(bus.pending[2]), 32'd0);
    n = 0;
    while (bus.door_open === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    check("t4_reload_len", 32'(n), 32'(DW));
    check("t4_pending2", 32'(bus.pending[2]), 32'd0);

    // reset in the middle of a downward sweep
    do_reset();
    bus.current_floor = 4'd9;
    bus.call_req      = 10'h0F0;
    cycle();
    bus.call_req = '0;
    cycle();
    check("t5_down_dir", 32'(bus.dir_up), 32'd0);
    check("t5_down_req", 32'(bus.requested_floor), 32'd7);
    do_reset();
    check("t5_pending", 32'(bus.pending), 32'd0);
    check("t5_req", 32'(bus.requested_floor), 32'd0);
    check("t5_door", 32'(bus.door_open), 32'd0);
    check("t5_dir", 32'(bus.dir_up), 32'd1);
    cycle();
    check("t5_idle_req", 32'(bus.requested_floor), 32'd9);

`ifdef DOOR_HOLD_EN
    do_reset();
    bus.current_floor = 4'd2;
    press(2);
    cycle();
    bus.call_req = '0;
    cycle();
    repeat (5) cycle();
    bus.door_hold = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      check("t6_held", 32'(bus.door_open), 32'd1);
    end
    bus.door_hold = 1'b0;
    n = 0;
    while (bus.door_open === 1'b1 && n < 60) begin
      n++;
      cycle();
    end
    check("t6_remaining", 32'(n), 32'(DW - 5));
`endif

    // randomized traffic with a plant that walks toward the modelled target
    do_reset();
    real_cf = '0;
    for (int c = 0; c < 3000; c++) begin
      bus.call_req = '0;
      if ($urandom_range(3) == 0) bus.call_req[$urandom_range(NF - 1)] = 1'b1;
      if ($urandom_range(15) == 0 && int'(real_cf) < NF) bus.call_req[real_cf] = 1'b1;
`ifdef DOOR_HOLD_EN
      bus.door_hold = ($urandom_range(7) == 0);
`endif
      if ($urandom_range(2) == 0) begin
        if (int'(real_cf) < m_req)      real_cf = real_cf + 4'd1;
        else if (int'(real_cf) > m_req) real_cf = real_cf - 4'd1;
      end
      if ($urandom_range(49) == 0) bus.current_floor = FW'(NF + $urandom_range(15 - NF));
      else                         bus.current_floor = real_cf;
      if (c == 1500) begin
        do_reset();
        real_cf = '0;
        bus.current_floor = real_cf;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
